// File: rtl/hid_enc_pkg.sv
// Shared constants, FSM state type and the ASCII-to-HID usage mapping for hid_key_encoder.
// Define HID_ENC_ARROW_EN to map codes 136..139 to the arrow-key usages.
package hid_enc_pkg;

  localparam logic [7:0] MOD_NONE   = 8'h00;
  localparam logic [7:0] MOD_LCTRL  = 8'h01;
  localparam logic [7:0] MOD_LSHIFT = 8'h02;

  localparam logic [7:0] KEY_1     = 8'd30;
  localparam logic [7:0] KEY_0     = 8'd39;
  localparam logic [7:0] KEY_ENTER = 8'd40;
  localparam logic [7:0] KEY_ESC   = 8'd41;
  localparam logic [7:0] KEY_BKSP  = 8'd42;
  localparam logic [7:0] KEY_TAB   = 8'd43;
  localparam logic [7:0] KEY_SPACE = 8'd44;
  localparam logic [7:0] KEY_MINUS = 8'd45;
  localparam logic [7:0] KEY_EQUAL = 8'd46;
  localparam logic [7:0] KEY_LBRK  = 8'd47;
  localparam logic [7:0] KEY_RBRK  = 8'd48;
  localparam logic [7:0] KEY_BSL   = 8'd49;
  localparam logic [7:0] KEY_SEMI  = 8'd51;
  localparam logic [7:0] KEY_QUOTE = 8'd52;
  localparam logic [7:0] KEY_GRAVE = 8'd53;
  localparam logic [7:0] KEY_COMMA = 8'd54;
  localparam logic [7:0] KEY_DOT   = 8'd55;
  localparam logic [7:0] KEY_SLASH = 8'd56;
  localparam logic [7:0] KEY_RIGHT = 8'd79;
  localparam logic [7:0] KEY_LEFT  = 8'd80;
  localparam logic [7:0] KEY_DOWN  = 8'd81;
  localparam logic [7:0] KEY_UP    = 8'd82;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LOOKUP,
    ST_PRESS,
    ST_RELEASE,
    ST_GAP
  } enc_state_t;

  typedef struct packed {
    logic       valid;
    logic [7:0] mod;
    logic [7:0] usage;
  } hid_key_t;

  function automatic hid_key_t hk(input logic [7:0] m, input logic [7:0] u);
    return '{valid: 1'b1, mod: m, usage: u};
  endfunction

  // Control codes 8, 9 and 13 are carved out of the ctrl+letter ranges so they map to BKSP/TAB/ENTER.
  function automatic hid_key_t ascii2hid(input logic [7:0] code);
    hid_key_t r;
    r = '0;
    case (code) inside
      [8'h61:8'h7A]: r = hk(MOD_NONE,   code - 8'h5D);
      [8'h41:8'h5A]: r = hk(MOD_LSHIFT, code - 8'h3D);
      [8'h31:8'h39]: r = hk(MOD_NONE,   code - 8'h13);
      8'h30:         r = hk(MOD_NONE,   KEY_0);
      8'h21:         r = hk(MOD_LSHIFT, KEY_1);
      8'h40:         r = hk(MOD_LSHIFT, KEY_1 + 8'd1);
      8'h23:         r = hk(MOD_LSHIFT, KEY_1 + 8'd2);
      8'h24:         r = hk(MOD_LSHIFT, KEY_1 + 8'd3);
      8'h25:         r = hk(MOD_LSHIFT, KEY_1 + 8'd4);
      8'h5E:         r = hk(MOD_LSHIFT, KEY_1 + 8'd5);
      8'h26:         r = hk(MOD_LSHIFT, KEY_1 + 8'd6);
      8'h2A:         r = hk(MOD_LSHIFT, KEY_1 + 8'd7);
      8'h28:         r = hk(MOD_LSHIFT, KEY_1 + 8'd8);
      8'h29:         r = hk(MOD_LSHIFT, KEY_0);
      8'd13:         r = hk(MOD_NONE,   KEY_ENTER);
      8'd27:         r = hk(MOD_NONE,   KEY_ESC);
      8'd8:          r = hk(MOD_NONE,   KEY_BKSP);
      8'd9:          r = hk(MOD_NONE,   KEY_TAB);
      8'd32:         r = hk(MOD_NONE,   KEY_SPACE);
      8'h2D:         r = hk(MOD_NONE,   KEY_MINUS);
      8'h3D:         r = hk(MOD_NONE,   KEY_EQUAL);
      8'h5B:         r = hk(MOD_NONE,   KEY_LBRK);
      8'h5D:         r = hk(MOD_NONE,   KEY_RBRK);
      8'h5C:         r = hk(MOD_NONE,   KEY_BSL);
      8'h3B:         r = hk(MOD_NONE,   KEY_SEMI);
      8'h27:         r = hk(MOD_NONE,   KEY_QUOTE);
      8'h60:         r = hk(MOD_NONE,   KEY_GRAVE);
      8'h2C:         r = hk(MOD_NONE,   KEY_COMMA);
      8'h2E:         r = hk(MOD_NONE,   KEY_DOT);
      8'h2F:         r = hk(MOD_NONE,   KEY_SLASH);
      8'h5F:         r = hk(MOD_LSHIFT, KEY_MINUS);
      8'h2B:         r = hk(MOD_LSHIFT, KEY_EQUAL);
      8'h7B:         r = hk(MOD_LSHIFT, KEY_LBRK);
      8'h7D:         r = hk(MOD_LSHIFT, KEY_RBRK);
      8'h7C:         r = hk(MOD_LSHIFT, KEY_BSL);
      8'h3A:         r = hk(MOD_LSHIFT, KEY_SEMI);
      8'h22:         r = hk(MOD_LSHIFT, KEY_QUOTE);
      8'h7E:         r = hk(MOD_LSHIFT, KEY_GRAVE);
      8'h3C:         r = hk(MOD_LSHIFT, KEY_COMMA);
      8'h3E:         r = hk(MOD_LSHIFT, KEY_DOT);
      8'h3F:         r = hk(MOD_LSHIFT, KEY_SLASH);
      [8'd1:8'd7], [8'd10:8'd12], [8'd14:8'd26]:
                     r = hk(MOD_LCTRL,  code + 8'd3);
`ifdef HID_ENC_ARROW_EN
      8'd136:        r = hk(MOD_NONE,   KEY_LEFT);
      8'd137:        r = hk(MOD_NONE,   KEY_RIGHT);
      8'd138:        r = hk(MOD_NONE,   KEY_DOWN);
      8'd139:        r = hk(MOD_NONE,   KEY_UP);
`endif
      default:       r = '0;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/hid_enc_fifo.sv
// Synchronous input FIFO for hid_key_encoder; pointers carry one extra wrap bit to tell full from empty.
module hid_enc_fifo #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             push_i,
  input  logic [WIDTH-1:0] din_i,
  input  logic             pop_i,
  output logic [WIDTH-1:0] dout_o,
  output logic             empty_o,
  output logic             full_o,
  output logic             full_nxt_o
);

  localparam int unsigned AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW:0]      wr_q, rd_q, wr_d, rd_d;
  logic             do_push, do_pop;

  assign empty_o    = (wr_q == rd_q);
  assign full_o     = ((wr_q ^ rd_q) == {1'b1, {AW{1'b0}}});
  assign do_push    = push_i & ~full_o;
  assign do_pop     = pop_i & ~empty_o;
  assign wr_d       = wr_q + {{AW{1'b0}}, do_push};
  assign rd_d       = rd_q + {{AW{1'b0}}, do_pop};
  assign full_nxt_o = ((wr_d ^ rd_d) == {1'b1, {AW{1'b0}}});
  assign dout_o     = mem[rd_q[AW-1:0]];

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wr_q <= '0;
      rd_q <= '0;
    end else begin
      wr_q <= wr_d;
      rd_q <= rd_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (do_push) mem[wr_q[AW-1:0]] <= din_i;
  end

endmodule

// File: rtl/hid_key_encoder.sv
// Character-stream to HID boot-keyboard report encoder: each code yields a press then a release report.
// Arrow-key codes 136..139 are only mapped when HID_ENC_ARROW_EN is defined.
module hid_key_encoder
  import hid_enc_pkg::*;
#(
  parameter int unsigned HOLD_CYCLES = 12000,
  parameter int unsigned GAP_CYCLES  = 12000,
  parameter int unsigned FIFO_DEPTH  = 4
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic [7:0] char_i,
  input  logic       char_valid_i,
  output logic       char_ready_o,
  output logic [1:0] typ_o,
  output logic       report_o,
  output logic [7:0] key_modifiers_o,
  output logic [7:0] key1_o,
  output logic [7:0] key2_o,
  output logic       busy_o,
  output logic       err_o
);

  localparam int unsigned CNT_MAX = (HOLD_CYCLES > GAP_CYCLES) ? HOLD_CYCLES : GAP_CYCLES;
  localparam int unsigned CW      = $clog2(CNT_MAX + 1);

  enc_state_t state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [7:0] code_q, code_d, key1_q, key1_d, mod_q, mod_d;
  logic report_q, report_d, err_q, err_d, ready_q;
  logic [1:0] typ_q;
  logic push, pop, fifo_empty, fifo_full, fifo_full_nxt;
  logic [7:0] fifo_dout;
  hid_key_t lut;

  assign push = char_valid_i & char_ready_o & ~fifo_full;
  assign lut  = ascii2hid(code_q);

  hid_enc_fifo #(
    .DEPTH(FIFO_DEPTH),
    .WIDTH(8)
  ) u_fifo (
    .clk_i      (clk_i),
    .rst_i      (rst_i),
    .push_i     (push),
    .din_i      (char_i),
    .pop_i      (pop),
    .dout_o     (fifo_dout),
    .empty_o    (fifo_empty),
    .full_o     (fifo_full),
    .full_nxt_o (fifo_full_nxt)
  );

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    code_d   = code_q;
    key1_d   = key1_q;
    mod_d    = mod_q;
    report_d = 1'b0;
    err_d    = 1'b0;
    pop      = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (!fifo_empty) begin
          pop     = 1'b1;
          code_d  = fifo_dout;
          state_d = ST_LOOKUP;
        end
      end
      ST_LOOKUP: begin
        if (!lut.valid) begin
          err_d   = 1'b1;
          state_d = ST_IDLE;
        end else begin
          key1_d   = lut.usage;
          mod_d    = lut.mod;
          report_d = 1'b1;
          cnt_d    = CW'(HOLD_CYCLES - 1);
          state_d  = ST_PRESS;
        end
      end
      ST_PRESS: begin
        if (cnt_q == '0) begin
          key1_d   = '0;
          mod_d    = '0;
          report_d = 1'b1;
          cnt_d    = CW'(GAP_CYCLES - 1);
          state_d  = ST_RELEASE;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      ST_RELEASE: state_d = ST_GAP;
      ST_GAP: begin
        if (cnt_q == '0) state_d = ST_IDLE;
        else             cnt_d   = cnt_q - 1'b1;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Ready is registered from the post-edge fill level so it always equals "not full" outside reset.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q  <= ST_IDLE;
      cnt_q    <= '0;
      code_q   <= '0;
      key1_q   <= '0;
      mod_q    <= '0;
      report_q <= 1'b0;
      err_q    <= 1'b0;
      ready_q  <= 1'b0;
      typ_q    <= 2'd0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      code_q   <= code_d;
      key1_q   <= key1_d;
      mod_q    <= mod_d;
      report_q <= report_d;
      err_q    <= err_d;
      ready_q  <= ~fifo_full_nxt;
      typ_q    <= 2'd1;
    end
  end

  assign char_ready_o    = ready_q;
  assign typ_o           = typ_q;
  assign report_o        = report_q;
  assign key_modifiers_o = mod_q;
  assign key1_o          = key1_q;
  assign key2_o          = '0;
  assign err_o           = err_q;
  assign busy_o          = (state_q != ST_IDLE) | ~fifo_empty;

endmodule

// File: tb/tb_hid_key_encoder.sv
// Self-checking bench for hid_key_encoder: directed vector table, corner sequences and randomized streams.
// Expected arrow-key results follow HID_ENC_ARROW_EN in the same way as the design.
module tb_hid_key_encoder;

  localparam int unsigned HOLD  = 4;
  localparam int unsigned GAP   = 3;
  localparam int unsigned DEPTH = 4;

  logic       clk = 1'b0;
  logic       rst_i = 1'b1;
  logic [7:0] char_i = '0;
  logic       char_valid_i = 1'b0;
  logic       char_ready_o, report_o, busy_o, err_o;
  logic [1:0] typ_o;
  logic [7:0] key_modifiers_o, key1_o, key2_o;

  hid_key_encoder #(
    .HOLD_CYCLES(HOLD),
    .GAP_CYCLES (GAP),
    .FIFO_DEPTH (DEPTH)
  ) dut (
    .clk_i           (clk),
    .rst_i           (rst_i),
    .char_i          (char_i),
    .char_valid_i    (char_valid_i),
    .char_ready_o    (char_ready_o),
    .typ_o           (typ_o),
    .report_o        (report_o),
    .key_modifiers_o (key_modifiers_o),
    .key1_o          (key1_o),
    .key2_o          (key2_o),
    .busy_o          (busy_o),
    .err_o           (err_o)
  );

  always #5 clk = ~clk;

  typedef struct {
    int         tag;
    bit         is_err;
    logic [7:0] mod;
    logic [7:0] key1;
    logic [7:0] key2;
  } ev_t;

  typedef struct {
    logic [7:0] code;
    bit         valid;
    logic [7:0] mod;
    logic [7:0] key;
  } vec_t;

  ev_t        ev_q[$];
  logic [7:0] acc_q[$];
  vec_t       vecs[$];
  int         cyc = 0;
  bit         busy_hist [16384];
  int         n_tests = 0;
  int         n_fail = 0;

  // A sample taken at a negedge is tagged with the number of the edge that closes that cycle.
  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    int t;
    t = cyc + 1;
    busy_hist[t % 16384] = busy_o;
    if (report_o) ev_q.push_back('{t, 1'b0, key_modifiers_o, key1_o, key2_o});
    if (err_o)    ev_q.push_back('{t, 1'b1, 8'h00, 8'h00, 8'h00});
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, got, exp);
    end
  endtask

  // Reference mapping built from lookup tables rather than code ranges.
  function automatic void ref_map(input logic [7:0] c, output bit v, output logic [7:0] m,
                                  output logic [7:0] k);
    string dig, sdig;
    int    pu [11];
    int    ps [11];
    int    pusage [11];
    int    sp_code [5];
    int    sp_use [5];
    pusage  = '{45, 46, 47, 48, 49, 51, 52, 53, 54, 55, 56};
    sp_code = '{13, 27, 8, 9, 32};
    sp_use  = '{40, 41, 42, 43, 44};
    pu      = '{'h2D, 'h3D, 'h5B, 'h5D, 'h5C, 'h3B, 'h27, 'h60, 'h2C, 'h2E, 'h2F};
    ps      = '{'h5F, 'h2B, 'h7B, 'h7D, 'h7C, 'h3A, 'h22, 'h7E, 'h3C, 'h3E, 'h3F};
    dig  = "1234567890";
    sdig = "!@#$%^&*()";
    v = 1'b0; m = 8'h00; k = 8'h00;
    if (c >= 8'h61 && c <= 8'h7A) begin v = 1; k = c - 8'h61 + 8'd4; end
    else if (c >= 8'h41 && c <= 8'h5A) begin v = 1; m = 8'h02; k = c - 8'h41 + 8'd4; end
    for (int i = 0; i < 10 && !v; i++) begin
      if (c == dig[i])  begin v = 1; k = 8'(30 + i); end
      if (c == sdig[i]) begin v = 1; m = 8'h02; k = 8'(30 + i); end
    end
    for (int i = 0; i < 5 && !v; i++)
      if (int'(c) == sp_code[i]) begin v = 1; k = 8'(sp_use[i]); end
    for (int i = 0; i < 11 && !v; i++) begin
      if (int'(c) == pu[i]) begin v = 1; k = 8'(pusage[i]); end
      if (int'(c) == ps[i]) begin v = 1; m = 8'h02; k = 8'(pusage[i]); end
    end
    if (!v && c >= 8'd1 && c <= 8'd26) begin v = 1; m = 8'h01; k = c + 8'd3; end
`ifdef HID_ENC_ARROW_EN
    if (!v && c >= 8'd136 && c <= 8'd139) begin
      int arrows [4];
      arrows = '{80, 79, 81, 82};
      v = 1; k = 8'(arrows[c - 8'd136]);
    end
`endif
  endfunction

  // Call at a negedge; returns at the negedge after acceptance with char_valid_i still high.
  task automatic push_char(input logic [7:0] c, output int acc, output bit stalled);
    int g;
    g = 0;
    stalled = 0;
    acc = -1;
    char_i = c;
    char_valid_i = 1'b1;
    while (!char_ready_o && g < 300) begin
      stalled = 1;
      @(negedge clk);
      g++;
    end
    if (g >= 300) chk("push_timeout", 32'd0, 32'd1);
    else begin
      acc = cyc + 1;
      acc_q.push_back(c);
      @(negedge clk);
    end
  endtask

  task automatic wait_idle(input int budget);
    int g;
    g = 0;
    while (busy_o && g < budget) begin
      @(negedge clk);
      g++;
    end
    if (g >= budget) chk("idle_timeout", 32'd0, 32'd1);
    @(negedge clk);
    @(negedge clk);
  endtask

  task automatic cmp_events(input string name);
    ev_t        exp_q[$];
    bit         v;
    logic [7:0] m, k;
    foreach (acc_q[i]) begin
      ref_map(acc_q[i], v, m, k);
      if (v) begin
        exp_q.push_back('{0, 1'b0, m, k, 8'h00});
        exp_q.push_back('{0, 1'b0, 8'h00, 8'h00, 8'h00});
      end else begin
        exp_q.push_back('{0, 1'b1, 8'h00, 8'h00, 8'h00});
      end
    end
    chk({name, "_count"}, ev_q.size(), exp_q.size());
    for (int i = 0; i < exp_q.size() && i < ev_q.size(); i++) begin
      chk($sformatf("%s_ev%0d_err", name, i), ev_q[i].is_err, exp_q[i].is_err);
      chk($sformatf("%s_ev%0d_mod", name, i), ev_q[i].mod, exp_q[i].mod);
      chk($sformatf("%s_ev%0d_key1", name, i), ev_q[i].key1, exp_q[i].key1);
      chk($sformatf("%s_ev%0d_key2", name, i), ev_q[i].key2, exp_q[i].key2);
    end
  endtask

  task automatic clear_logs();
    ev_q.delete();
    acc_q.delete();
  endtask

  task automatic wait_events(input int n, input int budget);
    int g;
    g = 0;
    while (ev_q.size() < n && g < budget) begin
      @(negedge clk);
      g++;
    end
    if (g >= budget) chk("event_timeout", 32'd0, 32'd1);
  endtask

  initial begin
    int   a, b, r, first_stall;
    bit   st;
    logic [7:0] seq [5];

    vecs.push_back('{8'h61, 1'b1, 8'h00, 8'h04});
    vecs.push_back('{8'h51, 1'b1, 8'h02, 8'h14});
    vecs.push_back('{8'h21, 1'b1, 8'h02, 8'h1E});
    vecs.push_back('{8'h03, 1'b1, 8'h01, 8'h06});
    vecs.push_back('{8'h0D, 1'b1, 8'h00, 8'h28});
    vecs.push_back('{8'h08, 1'b1, 8'h00, 8'h2A});
    vecs.push_back('{8'h1A, 1'b1, 8'h01, 8'h1D});
    vecs.push_back('{8'h1B, 1'b1, 8'h00, 8'h29});
    vecs.push_back('{8'h30, 1'b1, 8'h00, 8'h27});
    vecs.push_back('{8'h40, 1'b1, 8'h02, 8'h1F});
    vecs.push_back('{8'h5A, 1'b1, 8'h02, 8'h1D});
    vecs.push_back('{8'h7E, 1'b1, 8'h02, 8'h35});
    vecs.push_back('{8'h3F, 1'b1, 8'h02, 8'h38});
    vecs.push_back('{8'h5C, 1'b1, 8'h00, 8'h31});
    vecs.push_back('{8'h5D, 1'b1, 8'h00, 8'h30});
    vecs.push_back('{8'h20, 1'b1, 8'h00, 8'h2C});
    vecs.push_back('{8'h00, 1'b0, 8'h00, 8'h00});
    vecs.push_back('{8'h7F, 1'b0, 8'h00, 8'h00});
    vecs.push_back('{8'h80, 1'b0, 8'h00, 8'h00});
    vecs.push_back('{8'h8C, 1'b0, 8'h00, 8'h00});
`ifdef HID_ENC_ARROW_EN
    vecs.push_back('{8'h88, 1'b1, 8'h00, 8'h50});
    vecs.push_back('{8'h89, 1'b1, 8'h00, 8'h4F});
    vecs.push_back('{8'h8B, 1'b1, 8'h00, 8'h52});
`else
    vecs.push_back('{8'h88, 1'b0, 8'h00, 8'h00});
    vecs.push_back('{8'h89, 1'b0, 8'h00, 8'h00});
    vecs.push_back('{8'h8B, 1'b0, 8'h00, 8'h00});
`endif

    // Reset state
    repeat (3) @(negedge clk);
    chk("rst_typ", typ_o, 2'd0);
    chk("rst_report", report_o, 1'b0);
    chk("rst_key1", key1_o, 8'h00);
    chk("rst_mod", key_modifiers_o, 8'h00);
    chk("rst_key2", key2_o, 8'h00);
    chk("rst_busy", busy_o, 1'b0);
    chk("rst_err", err_o, 1'b0);
    chk("rst_ready", char_ready_o, 1'b0);
    rst_i = 1'b0;
    @(negedge clk);
    chk("post_rst_ready", char_ready_o, 1'b1);
    chk("post_rst_typ", typ_o, 2'd1);
    clear_logs();

    // Vector table: mapping, latency and hold time per code
    foreach (vecs[i]) begin
      clear_logs();
      push_char(vecs[i].code, a, st);
      char_valid_i = 1'b0;
      wait_idle(100);
      if (vecs[i].valid) begin
        chk($sformatf("vec%0d_count", i), ev_q.size(), 2);
        if (ev_q.size() >= 2) begin
          chk($sformatf("vec%0d_press_err", i), ev_q[0].is_err, 1'b0);
          chk($sformatf("vec%0d_press_mod", i), ev_q[0].mod, vecs[i].mod);
          chk($sformatf("vec%0d_press_key1", i), ev_q[0].key1, vecs[i].key);
          chk($sformatf("vec%0d_rel_mod", i), ev_q[1].mod, 8'h00);
          chk($sformatf("vec%0d_rel_key1", i), ev_q[1].key1, 8'h00);
          chk($sformatf("vec%0d_latency", i), ev_q[0].tag - a, 3);
          chk($sformatf("vec%0d_hold", i), ev_q[1].tag - ev_q[0].tag, HOLD);
        end
      end else begin
        chk($sformatf("vec%0d_count", i), ev_q.size(), 1);
        if (ev_q.size() >= 1) chk($sformatf("vec%0d_err", i), ev_q[0].is_err, 1'b1);
      end
    end

    // 'a': busy stays high through the gap and drops right after it
    clear_logs();
    push_char(8'h61, a, st);
    char_valid_i = 1'b0;
    wait_idle(100);
    cmp_events("t1");
    if (ev_q.size() >= 2) begin
      r = ev_q[1].tag;
      chk("t1_busy_end_gap", busy_hist[(r + GAP) % 16384], 1'b1);
      chk("t1_busy_low", busy_hist[(r + GAP + 1) % 16384], 1'b0);
    end

    // 'Q' then '!' back to back: press-to-press spacing
    clear_logs();
    push_char(8'h51, a, st);
    push_char(8'h21, b, st);
    char_valid_i = 1'b0;
    wait_idle(100);
    cmp_events("t2");
    if (ev_q.size() >= 3) chk("t2_spacing", ev_q[2].tag - ev_q[0].tag, HOLD + 1 + GAP + 2);

    // 03h then 0Dh: ctrl+C followed by ENTER (not ctrl+M)
    clear_logs();
    push_char(8'h03, a, st);
    push_char(8'h0D, b, st);
    char_valid_i = 1'b0;
    wait_idle(100);
    cmp_events("t3");

    // FIFO fills while the FSM is holding a key
    clear_logs();
    push_char(8'h7A, a, st);
    char_valid_i = 1'b0;
    wait_events(1, 50);
    seq = '{8'h31, 8'h32, 8'h33, 8'h34, 8'h35};
    first_stall = -1;
    for (int i = 0; i < 5; i++) begin
      push_char(seq[i], a, st);
      if (st && first_stall < 0) first_stall = i;
    end
    char_valid_i = 1'b0;
    chk("t4_ready_drop_after", first_stall, 4);
    wait_idle(400);
    cmp_events("t4");

    // 80h, 89h
    clear_logs();
    push_char(8'h80, a, st);
    push_char(8'h89, b, st);
    char_valid_i = 1'b0;
    wait_idle(100);
    cmp_events("t5");

    // Reset during PRESS with two codes still queued
    clear_logs();
    push_char(8'h62, a, st);
    push_char(8'h63, a, st);
    push_char(8'h64, a, st);
    char_valid_i = 1'b0;
    wait_events(1, 50);
    rst_i = 1'b1;
    @(negedge clk);
    chk("t6_key1", key1_o, 8'h00);
    chk("t6_mod", key_modifiers_o, 8'h00);
    chk("t6_report", report_o, 1'b0);
    chk("t6_typ", typ_o, 2'd0);
    chk("t6_busy", busy_o, 1'b0);
    rst_i = 1'b0;
    clear_logs();
    repeat (40) @(negedge clk);
    chk("t6_no_reports", ev_q.size(), 0);
    chk("t6_idle", busy_o, 1'b0);
    chk("t6_ready", char_ready_o, 1'b1);

    // Randomized streams against the reference model
    for (int blk = 0; blk < 4; blk++) begin
      clear_logs();
      for (int i = 0; i < 12; i++) begin
        logic [7:0] c;
        if ($urandom_range(0, 3) == 0) c = 8'($urandom_range(128, 255));
        else                           c = 8'($urandom_range(0, 127));
        push_char(c, a, st);
        char_valid_i = 1'b0;
        repeat ($urandom_range(0, 3)) @(negedge clk);
      end
      wait_idle(600);
      cmp_events($sformatf("rnd%0d", blk));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
